// File: rtl/ifetch_unit.sv
// Instruction fetch unit for minisys-32: owns the PC, fetches one word per
// instruction over a req/ready handshake and resolves the next PC from Controller flow control.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst,

    output logic                   imem_req,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic                   imem_ready,
    input  logic [31:0]            imem_rdata,

    input  logic                   stall,
    input  logic                   Jr,
    input  logic                   Jmp,
    input  logic                   Jal,
    input  logic                   Branch,
    input  logic                   nBranch,
    input  logic                   Zero,
    input  logic [31:0]            Read_data_1,
    input  logic [31:0]            Imm_extend,

    output logic [31:0]            Inst,
    output logic                   inst_valid,
    output logic [31:0]            PC,
    output logic [31:0]            link_addr,
    output logic                   pc_misalign
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] link_q;
    logic        req_q;
    logic        valid_q;
    logic        misalign_q;

    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] pc_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pc4    = pc_q + 32'd4;
        br_tgt = pc4 + (Imm_extend << 2);
        j_tgt  = {pc4[31:28], inst_q[25:0], 2'b00};
        pc_d   = pc4;

        if (Jr) begin
            pc_d = Read_data_1 & ~32'h3;
        end else if (Jmp || Jal) begin
            pc_d = j_tgt;
        end else if (Branch && Zero) begin
            pc_d = br_tgt;
        end else if (nBranch && !Zero) begin
            pc_d = br_tgt;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0;
            link_q     <= 32'h0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    // Request is registered, so the first fetch cycle after reset
                    // only raises it; ready is meaningful only while req is high.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ready) begin
                        inst_q  <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        pc_q       <= pc_d;
                        misalign_q <= Jr && (Read_data_1[1:0] != 2'b00);
                        if (Jal) begin
                            link_q <= pc4;
                        end
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q[IMEM_ADDR_W+1:2];
    assign Inst        = inst_q;
    assign inst_valid  = valid_q;
    assign PC          = pc_q;
    assign link_addr   = link_q;
    assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a chained table of instruction records plus
// hand-written reset and stall sequences, with fetched words tracked by a scoreboard.
module tb_ifetch_unit;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic [31:0]   imem_rdata;
    logic          stall;
    logic          Jr, Jmp, Jal, Branch, nBranch, Zero;
    logic [31:0]   Read_data_1, Imm_extend;
    logic [31:0]   Inst;
    logic          inst_valid;
    logic [31:0]   PC;
    logic [31:0]   link_addr;
    logic          pc_misalign;

    ifetch_unit #(.RESET_PC(32'h0), .IMEM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .Jr(Jr), .Jmp(Jmp), .Jal(Jal),
        .Branch(Branch), .nBranch(nBranch), .Zero(Zero),
        .Read_data_1(Read_data_1), .Imm_extend(Imm_extend),
        .Inst(Inst), .inst_valid(inst_valid), .PC(PC),
        .link_addr(link_addr), .pc_misalign(pc_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        int          waits;
        int          stalls;
        logic        jr, jmp, jal, br, nbr, zero;
        logic [31:0] rd1, imm;
        logic [31:0] pc, next, link;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    vec_t        vecs [21];
    sb_t         sb [$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] prev_link;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_flow();
        Jr = 0; Jmp = 0; Jal = 0; Branch = 0; nBranch = 0; Zero = 0;
        Read_data_1 = 32'h0; Imm_extend = 32'h0;
    endtask

    task automatic wait_req();
        for (int k = 0; k < 4 && imem_req !== 1'b1; k++) @(negedge clk);
        check("req_raised", {31'h0, imem_req}, 32'h1);
    endtask

    // Entered at a negedge in the fetch state; leaves at the negedge after the exec exit.
    task automatic run_vec(input vec_t v, input int idx);
        sb_t   got;
        string tag;
        tag = $sformatf("v%0d", idx);
        check({tag, "_req"}, {31'h0, imem_req}, 32'h1);
        check({tag, "_addr"}, {18'h0, imem_addr}, {18'h0, v.pc[AW+1:2]});
        for (int w = 0; w < v.waits; w++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            check({tag, "_wait_req"}, {31'h0, imem_req}, 32'h1);
            check({tag, "_wait_addr"}, {18'h0, imem_addr}, {18'h0, v.pc[AW+1:2]});
            check({tag, "_wait_valid"}, {31'h0, inst_valid}, 32'h0);
            check({tag, "_wait_mis"}, {31'h0, pc_misalign}, 32'h0);
        end
        imem_ready = 1'b1;
        imem_rdata = v.inst;
        sb.push_back('{pc: v.pc, inst: v.inst});
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        for (int k = 0; k < 4 && inst_valid !== 1'b1; k++) @(negedge clk);
        check({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
        check({tag, "_exec_req"}, {31'h0, imem_req}, 32'h0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            got = sb.pop_front();
            check({tag, "_pc"}, PC, got.pc);
            check({tag, "_inst"}, Inst, got.inst);
        end
        Jr = v.jr; Jmp = v.jmp; Jal = v.jal; Branch = v.br; nBranch = v.nbr; Zero = v.zero;
        Read_data_1 = v.rd1; Imm_extend = v.imm;
        stall = 1'b1;
        for (int s = 0; s < v.stalls; s++) begin
            @(negedge clk);
            check({tag, "_stall_pc"}, PC, v.pc);
            check({tag, "_stall_inst"}, Inst, v.inst);
            check({tag, "_stall_valid"}, {31'h0, inst_valid}, 32'h1);
            check({tag, "_stall_link"}, link_addr, prev_link);
        end
        stall = 1'b0;
        @(negedge clk);
        clear_flow();
        check({tag, "_next_pc"}, PC, v.next);
        check({tag, "_next_addr"}, {18'h0, imem_addr}, {18'h0, v.next[AW+1:2]});
        check({tag, "_link"}, link_addr, v.link);
        check({tag, "_mis"}, {31'h0, pc_misalign}, {31'h0, v.mis});
        check({tag, "_fetch_valid"}, {31'h0, inst_valid}, 32'h0);
        prev_link = v.link;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // inst, waits, stalls, jr, jmp, jal, br, nbr, zero, rd1, imm, pc, next, link, mis
        vecs[0]  = '{32'h0, 0, 0, 0,0,0,0,0,0, 32'h0, 32'h0, 32'h0000_0000, 32'h0000_0004, 32'h0, 0};
        vecs[1]  = '{32'h0, 0, 0, 0,0,0,0,0,0, 32'h0, 32'h0, 32'h0000_0004, 32'h0000_0008, 32'h0, 0};
        vecs[2]  = '{32'h0, 0, 5, 0,0,0,0,0,0, 32'h0, 32'h0, 32'h0000_0008, 32'h0000_000C, 32'h0, 0};
        vecs[3]  = '{32'h0, 0, 0, 0,0,0,0,0,0, 32'h0, 32'h0, 32'h0000_000C, 32'h0000_0010, 32'h0, 0};
        vecs[4]  = '{32'h0, 3, 0, 0,0,0,0,0,0, 32'h0, 32'h0, 32'h0000_0010, 32'h0000_0014, 32'h0, 0};
        vecs[5]  = '{32'h0800_0008, 0, 0, 0,1,0,0,0,0, 32'h0, 32'h0, 32'h0000_0014, 32'h0000_0020, 32'h0, 0};
        vecs[6]  = '{32'h0, 0, 0, 0,0,0,1,0,1, 32'h0, 32'hFFFF_FFFE, 32'h0000_0020, 32'h0000_001C, 32'h0, 0};
        vecs[7]  = '{32'h0800_0008, 0, 0, 0,1,0,0,0,0, 32'h0, 32'h0, 32'h0000_001C, 32'h0000_0020, 32'h0, 0};
        vecs[8]  = '{32'h0, 0, 0, 0,0,0,1,0,0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0020, 32'h0000_0024, 32'h0, 0};
        vecs[9]  = '{32'h0800_0008, 0, 0, 0,1,0,0,0,0, 32'h0, 32'h0, 32'h0000_0024, 32'h0000_0020, 32'h0, 0};
        vecs[10] = '{32'h0, 0, 0, 0,0,0,0,1,0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0020, 32'h0000_001C, 32'h0, 0};
        vecs[11] = '{32'h0, 0, 0, 0,0,0,0,1,1, 32'h0, 32'h0000_0005, 32'h0000_001C, 32'h0000_0020, 32'h0, 0};
        vecs[12] = '{32'h0, 0, 0, 0,0,0,1,1,0, 32'h0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0064, 32'h0, 0};
        vecs[13] = '{32'h0, 0, 0, 1,0,0,0,0,0, 32'h4000_0100, 32'h0, 32'h0000_0064, 32'h4000_0100, 32'h0, 0};
        vecs[14] = '{32'h0C00_0040, 0, 2, 0,0,1,0,0,0, 32'h0, 32'h0, 32'h4000_0100, 32'h4000_0100, 32'h4000_0104, 0};
        vecs[15] = '{32'h0, 0, 0, 1,0,0,0,0,0, 32'h4000_0106, 32'h0, 32'h4000_0100, 32'h4000_0104, 32'h4000_0104, 1};
        vecs[16] = '{32'h0C00_0000, 1, 0, 1,0,1,0,0,0, 32'h0000_0200, 32'h0, 32'h4000_0104, 32'h0000_0200, 32'h4000_0108, 0};
        vecs[17] = '{32'h0, 0, 0, 1,0,0,0,0,0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0200, 32'hFFFF_FFFC, 32'h4000_0108, 0};
        vecs[18] = '{32'h0, 0, 0, 0,0,0,0,0,0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h4000_0108, 0};
        vecs[19] = '{32'h0, 0, 0, 0,0,0,1,0,1, 32'h0, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFC, 32'h4000_0108, 0};
        vecs[20] = '{32'h0800_0001, 0, 0, 0,1,0,0,0,0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0004, 32'h4000_0108, 0};

        rst = 1'b1; stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        clear_flow();
        prev_link = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_pc", PC, 32'h0);
        check("rst_inst", Inst, 32'h0);
        check("rst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_link", link_addr, 32'h0);
        check("rst_mis", {31'h0, pc_misalign}, 32'h0);
        rst = 1'b0;
        wait_req();

        for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

        // Reset lands on a fetch cycle whose ready is high: the word must be dropped.
        rst = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("midrst_inst", Inst, 32'h0);
        check("midrst_pc", PC, 32'h0);
        check("midrst_valid", {31'h0, inst_valid}, 32'h0);
        check("midrst_req", {31'h0, imem_req}, 32'h0);
        check("midrst_link", link_addr, 32'h0);
        rst = 1'b0;
        imem_ready = 1'b0;
        prev_link = 32'h0;
        wait_req();
        check("postrst_addr", {18'h0, imem_addr}, 32'h0);
        run_vec(vecs[0], 99);

        if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch unit for the minisys-32 CPU.
- Owns the PC, issues word reads to instruction memory over a req/ready handshake, and presents the fetched word as Inst to the Controller and datapath.
- Consumes the Controller's decoded flow-control outputs (Jr, Jmp, Jal, Branch, nBranch) plus datapath Zero, register and immediate values to select the next PC, and produces the Jal link address.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; must be word aligned.
- IMEM_ADDR_W, 14, width of the instruction-memory word address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  IMEM_ADDR_W  word address, equal to PC[IMEM_ADDR_W+1:2].
- imem_ready  input  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  instruction word from memory.
- stall  input  1  downstream hold; freezes the unit in S_EXEC.
- Jr, Jmp, Jal, Branch, nBranch  input  1 each  Controller flow-control outputs decoded from Inst.
- Zero  input  1  ALU zero flag for the current instruction.
- Read_data_1  input  32  rs register value, used as the Jr target.
- Imm_extend  input  32  sign-extended 16-bit immediate of Inst.
- Inst  output  32  current instruction word.
- inst_valid  output  1  Inst is valid and being executed.
- PC  output  32  byte address of Inst.
- link_addr  output  32  PC+4 captured on a Jal.
- pc_misalign  output  1  one-cycle pulse when a Jr target has bits [1:0] != 0.

Behaviour:
- Reset (rst=1 at an edge): PC=RESET_PC, Inst=0, inst_valid=0, imem_req=0, link_addr=0, pc_misalign=0, state goes to S_FETCH.
  - Reset overrides every other input in any state.
  - A fetch in flight is abandoned; an imem_ready seen in the reset cycle is ignored.
- S_FETCH:
  - imem_req=1; imem_addr=PC[IMEM_ADDR_W+1:2] held stable while waiting; inst_valid=0.
  - imem_ready=0: stay in S_FETCH, keep request asserted.
  - imem_ready=1: Inst<=imem_rdata, next state S_EXEC.
- S_EXEC:
  - imem_req=0, inst_valid=1. The Controller decodes Inst combinationally and flow-control inputs are sampled in this state.
  - stall=1: hold PC, Inst and link_addr; stay in S_EXEC.
  - stall=0: PC<=next_pc, next state S_FETCH.
- Latency: ready sampled in cycle N gives inst_valid in cycle N+1. Minimum throughput is one instruction per 2 cycles.
- PC arithmetic, all modulo 2^32:
  - pc4 = PC+4.
  - br_tgt = pc4 + (Imm_extend<<2).
  - j_tgt = {pc4[31:28], Inst[25:0], 2'b00}.
- next_pc priority, highest first:
  1. Jr: Read_data_1 & ~32'h3.
  2. Jmp or Jal: j_tgt.
  3. Branch & Zero: br_tgt.
  4. nBranch & ~Zero: br_tgt.
  5. Otherwise: pc4.
- Untaken branches (Branch&~Zero, nBranch&Zero) fall through to pc4.
- link_addr <= pc4 on the S_EXEC->S_FETCH edge when Jal=1; otherwise it holds its value.
- pc_misalign = 1 for exactly the cycle after the S_EXEC exit edge where Jr=1 and Read_data_1[1:0]!=0; otherwise 0.
- Wrap-around:
  - PC=32'hFFFF_FFFC falling through gives PC=0.
  - A negative Imm_extend that underflows wraps; no flag is raised.
- Simultaneous signals:
  - Jr together with Jmp/Jal: Jr wins; link_addr still updates if Jal=1.
  - Branch and nBranch together: Branch term is evaluated first.

Test Plan:
- Sequential fetch from reset: RESET_PC=0, imem_ready=1 every cycle, no flow control, memory holds sequential NOPs. Expect PC=0,4,8,C on successive S_EXEC cycles, inst_valid pattern 0,1,0,1,…, imem_addr 0,1,2,3.
- Wait states: imem_ready low 3 cycles at PC=0x10. Expect imem_req held high and imem_addr=4 for 4 cycles; Inst captured on the ready cycle; inst_valid one cycle later.
- Taken and untaken branch: PC=0x20, Imm_extend=32'hFFFF_FFFE.
  - Branch=1, Zero=1: next PC=0x1C.
  - Branch=1, Zero=0: next PC=0x24.
  - nBranch=1, Zero=0: next PC=0x1C.
- Jal then Jr: PC=0x4000_0100, Inst[25:0]=26'h0000040, Jal=1. Expect next PC=0x4000_0100 and link_addr=0x4000_0104. Then Jr=1, Read_data_1=0x4000_0106: expect PC=0x4000_0104 and a pc_misalign pulse.
- Stall and reset mid-operation:
  - stall=1 for 5 cycles in S_EXEC: PC and Inst frozen, inst_valid stays 1.
  - rst asserted during S_FETCH with imem_ready=1 in the same cycle: outputs take reset values, Inst=0.
  - After reset, the next request goes to RESET_PC.
- Wrap: PC=0xFFFF_FFFC with no flow control. Expect next PC=0 and imem_addr=0.
